// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: extension mode encodings shared by the immediate extender and its bench.
package imm_ext_pkg;
    localparam int MODE_W = 2;
    typedef enum logic [MODE_W-1:0] {
        SEXT      = 2'b00,
        ZEXT      = 2'b01,
        SEXT_SHL1 = 2'b10,
        UPPER     = 2'b11
    } imm_mode_t;
endpackage

// File: rtl/imm_ext_skid.sv
// imm_ext_skid: valid/ready output buffer; 2-entry skid with registered in_ready when
// IMM_EXTENDER_SKID_EN is defined, otherwise a single pass-through-ready register.
module imm_ext_skid #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic push;
    logic pop;
    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;
`ifdef IMM_EXTENDER_SKID_EN
    logic         skid_valid;
    logic [W-1:0] skid_data;
    // ready depends only on state, so out_ready never reaches in_ready combinationally
    assign in_ready = rst_n && !skid_valid;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (skid_valid) begin
            if (pop) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (push) begin
            if (!out_valid || pop) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end
`else
    assign in_ready = rst_n && (!out_valid || out_ready);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (push) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end
`endif
endmodule

// File: rtl/imm_extender.sv
// imm_extender: registered immediate sign/zero/shift/upper extender with valid/ready flow.
// Define IMM_EXTENDER_SKID_EN for a 2-entry skid buffer with registered in_ready.
module imm_extender
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic [MODE_W-1:0] in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [MODE_W-1:0] out_mode
);
    localparam int PW = OUT_W + MODE_W;
    if (IN_W > OUT_W) begin : g_bad_width
        $error("imm_extender: IN_W must not exceed OUT_W");
    end
    imm_mode_t        mode;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] ext;
    logic [PW-1:0]    payload;
    assign mode = imm_mode_t'(in_mode);
    // size casts keep the IN_W == OUT_W case free of zero-width replications
    assign sext = OUT_W'($signed(in_data));
    assign zext = OUT_W'(in_data);
    always_comb begin
        ext = mode == SEXT      ? sext :
              mode == ZEXT      ? zext :
              mode == SEXT_SHL1 ? sext << 1 :
                                  zext << (OUT_W - IN_W);
    end
    assign payload = {in_mode, ext};
    logic [PW-1:0] held;
    imm_ext_skid #(.W(PW)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (held)
    );
    assign out_data = held[OUT_W-1:0];
    assign out_mode = held[PW-1:OUT_W];
endmodule

// File: tb/tb_imm_extender.sv
// tb_imm_extender: directed and scoreboarded checks of imm_extender (IN_W=4, OUT_W=16).
module tb_imm_extender;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_mode;
    int passed = 0;
    int total = 0;
`ifdef IMM_EXTENDER_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    imm_extender #(.IN_W(4), .OUT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [15:0] model(input logic [1:0] m, input logic [3:0] d);
        case (m)
            2'b00:   return {{12{d[3]}}, d};
            2'b01:   return {12'h000, d};
            2'b10:   return {{11{d[3]}}, d, 1'b0};
            default: return {d, 12'h000};
        endcase
    endfunction
    task automatic send(input string tag, input logic [1:0] m, input logic [3:0] d, input logic [15:0] exp);
        in_valid = 1'b1;
        in_mode = m;
        in_data = d;
        out_ready = 1'b1;
        #1;
        check({tag, " ready"}, 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        #1;
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " data"}, 32'(out_data), 32'(exp));
        check({tag, " mode"}, 32'(out_mode), 32'(m));
        tick;
    endtask
    logic [17:0] sb[$];
    logic [17:0] e;
    logic        stall;
    logic [15:0] pd;
    logic [1:0]  pm;
    int acc;
    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 4'h0;
        in_mode = 2'b00;
        out_ready = 1'b0;
        #1;
        check("rst ready low", 32'(in_ready), 32'd0);
        tick;
        tick;
        check("rst valid", 32'(out_valid), 32'd0);
        check("rst data", 32'(out_data), 32'd0);
        check("rst mode", 32'(out_mode), 32'd0);
        check("rst ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post rst ready", 32'(in_ready), 32'd1);
        send("sext A", 2'b00, 4'hA, 16'hFFFA);
        send("zext A", 2'b01, 4'hA, 16'h000A);
        send("shl1 9", 2'b10, 4'h9, 16'hFFF2);
        send("upper A", 2'b11, 4'hA, 16'hA000);
        send("sext 7", 2'b00, 4'h7, 16'h0007);
        send("sext 8", 2'b00, 4'h8, 16'hFFF8);
        send("zext F", 2'b01, 4'hF, 16'h000F);
        send("shl1 7", 2'b10, 4'h7, 16'h000E);
        send("upper 1", 2'b11, 4'h1, 16'h1000);
        // back-to-back SEXT stream, one result per cycle
        out_ready = 1'b1;
        in_mode = 2'b00;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data = 4'(i);
            tick;
            check("stream valid", 32'(out_valid), 32'd1);
            check("stream data", 32'(out_data), i < 8 ? 32'(i) : 32'(16'hFFF0 | 16'(i)));
        end
        in_valid = 1'b0;
        tick;
        check("stream empty", 32'(out_valid), 32'd0);
        // output stall: capacity fills, head held
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data = 4'(3 + acc);
            #1;
            check("stall ready", 32'(in_ready), c < CAP ? 32'd1 : 32'd0);
            if (in_ready) acc++;
            tick;
            check("stall hold", 32'(out_data), 32'h0003);
        end
        check("stall accepted", 32'(acc), 32'(CAP));
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < acc; k++) begin
            #1;
            check("drain valid", 32'(out_valid), 32'd1);
            check("drain data", 32'(out_data), 32'(3 + k));
            tick;
        end
        check("drain empty", 32'(out_valid), 32'd0);
        check("drain ready", 32'(in_ready), 32'd1);
        // reset while holding buffered UPPER items
        out_ready = 1'b0;
        in_mode = 2'b11;
        in_valid = 1'b1;
        in_data = 4'h5;
        tick;
        in_data = 4'h6;
        tick;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst ready", 32'(in_ready), 32'd0);
        tick;
        check("midrst valid", 32'(out_valid), 32'd0);
        check("midrst data", 32'(out_data), 32'd0);
        check("midrst mode", 32'(out_mode), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick;
        tick;
        check("no stale", 32'(out_valid), 32'd0);
        send("after rst", 2'b00, 4'h1, 16'h0001);
        // random handshakes against a queue model
        stall = 1'b0;
        pd = '0;
        pm = '0;
        for (int n = 0; n < 3000; n++) begin
            if (stall) begin
                check("rnd hold valid", 32'(out_valid), 32'd1);
                check("rnd hold data", 32'(out_data), 32'(pd));
                check("rnd hold mode", 32'(out_mode), 32'(pm));
            end
            in_valid = 1'($urandom_range(0, 1));
            in_data = 4'($urandom);
            in_mode = 2'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("rnd extra", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    check("rnd data", 32'(out_data), 32'(e[15:0]));
                    check("rnd mode", 32'(out_mode), 32'(e[17:16]));
                end
            end
            if (in_valid && in_ready) sb.push_back({in_mode, model(in_mode, in_data)});
            stall = out_valid && !out_ready;
            pd = out_data;
            pm = out_mode;
            tick;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (out_valid) begin
                if (sb.size() == 0) check("rnd drain extra", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    check("rnd drain data", 32'(out_data), 32'(e[15:0]));
                end
            end
            tick;
        end
        check("rnd lost", 32'(sb.size()), 32'd0);
        check("rnd final empty", 32'(out_valid), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
